// File: rtl/calc_datapath.sv
// rtl/calc_datapath.sv - 8x8 shift-add multiplier with registered display; CALC_ACCUMULATE_EN adds the product to the display
module calc_datapath (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  operand_in,
    input  logic        save_A,
    input  logic        save_B,
    input  logic        show_result,
    output logic [15:0] display,
    output logic        display_valid,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t      state, state_next;
    logic [7:0]  reg_A, reg_B;
    logic [15:0] mcand, acc, acc_step, product, disp_next;
    logic [2:0]  cnt;
    logic        pending, start, last_step, publish_now;

    // The multiplier bit is selected by the step counter, so reg_B stays intact during MUL
    assign acc_step  = acc + (reg_B[cnt] ? mcand : 16'd0);
    assign start     = save_B && (state != MUL);
    assign last_step = (state == MUL) && (cnt == 3'd7);
    assign busy      = (state == MUL);
    assign done      = (state == DONE);

    // A pending request publishes the final sum on the edge that enters DONE
    assign product     = (state == DONE) ? acc : acc_step;
    assign publish_now = !save_A &&
                         (((state == DONE) && show_result) ||
                          (last_step && (pending || show_result)));

`ifdef CALC_ACCUMULATE_EN
    assign disp_next = display + product;
`else
    assign disp_next = product;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (save_B) state_next = MUL;
            MUL:     if (cnt == 3'd7) state_next = DONE;
            DONE:    if (save_B) state_next = MUL;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_A         <= 8'd0;
            reg_B         <= 8'd0;
            mcand         <= 16'd0;
            acc           <= 16'd0;
            cnt           <= 3'd0;
            pending       <= 1'b0;
            display       <= 16'd0;
            display_valid <= 1'b0;
        end else begin
            if (save_A) begin
                reg_A <= operand_in;
            end

            if (start) begin
                reg_B <= operand_in;
                mcand <= {8'd0, reg_A};
                acc   <= 16'd0;
                cnt   <= 3'd0;
            end else if (state == MUL) begin
                acc   <= acc_step;
                mcand <= mcand << 1;
                cnt   <= cnt + 3'd1;
            end

            if (save_A || last_step) begin
                pending <= 1'b0;
            end else if ((state == MUL) && show_result) begin
                pending <= 1'b1;
            end

            if (publish_now) begin
                display <= disp_next;
            end

            if (save_A) begin
                display_valid <= 1'b0;
            end else if (publish_now) begin
                display_valid <= 1'b1;
            end
        end
    end

endmodule

// File: doc/calc_datapath.md
CALC_DATAPATH -- requirements
Module: calc_datapath

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports SHALL be as listed in REQ-002..REQ-011.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 operand_in  input  8  unsigned operand from the board switches.
REQ-005 save_A  input  1  single-cycle strobe: capture operand_in as operand A.
REQ-006 save_B  input  1  single-cycle strobe: capture operand_in as operand B and start the multiply.
REQ-007 show_result  input  1  single-cycle strobe: publish the product to the display.
REQ-008 display  output  16  registered result shown to the user.
REQ-009 display_valid  output  1  high while display holds a result published since the last save_A.
REQ-010 busy  output  1  high while the multiply is in progress.
REQ-011 done  output  1  high from multiply completion until the next save_B or reset.

Function
REQ-012 The block SHALL implement states IDLE, MUL and DONE; the reset state SHALL be IDLE.
REQ-013 save_A SHALL load reg_A <= operand_in on the same clock edge in any state.
REQ-014 save_B in IDLE or DONE SHALL load reg_B <= operand_in, load the multiplicand from reg_A's value before that edge, clear the accumulator and step counter, and enter MUL.
REQ-015 MUL SHALL perform unsigned shift-add multiplication, one multiplier bit per cycle, LSB first, for exactly 8 cycles.
REQ-016 busy SHALL be high for exactly 8 cycles starting the cycle after the save_B edge; the state SHALL be DONE and done SHALL be 1 on the 9th cycle.
REQ-017 The 16-bit product SHALL be exact for all 8x8 unsigned inputs; no truncation is allowed (255*255 = 0xFE01).
REQ-018 save_B during MUL SHALL be ignored: no restart, reg_B unchanged.
REQ-019 save_A during MUL SHALL update reg_A only; the running multiply SHALL be unaffected.
REQ-020 show_result in DONE SHALL update display and set display_valid=1 on that edge.
REQ-021 show_result during MUL SHALL set a pending flag; display SHALL update on the edge entering DONE, and the pending flag SHALL then clear.
REQ-022 show_result in IDLE with no completed product SHALL be ignored.
REQ-023 save_A SHALL clear display_valid and any pending flag; display SHALL keep its old value.
REQ-024 If save_A and show_result occur together, save_A SHALL take priority: display_valid=0 and display unchanged.
REQ-025 done SHALL clear on the edge that accepts a new save_B.

Reset
REQ-026 rst_n=0 SHALL immediately force state=IDLE and clear reg_A, reg_B, accumulator, counter, pending flag, display=0x0000, display_valid=0, busy=0 and done=0.
REQ-027 Reset asserted during MUL SHALL abort the multiply; no partial product SHALL reach display after reset is released.

Configuration
REQ-028 With macro CALC_ACCUMULATE_EN defined, publishing SHALL load display <= display + product, modulo 2^16.
REQ-029 Without CALC_ACCUMULATE_EN, publishing SHALL load display <= product; all other behaviour SHALL be identical in both builds.

Verification
REQ-030 A=12, B=13, show_result after done -> busy high for 8 cycles, then display=0x009C and display_valid=1.
REQ-031 A=255, B=255 -> display=0xFE01; A=0, B=200 -> display=0x0000.
REQ-032 show_result 3 cycles after save_B -> display updates on the edge entering DONE; a second save_B during MUL is ignored.
REQ-033 save_A (new value 7) during MUL on 12x13 -> result still 0x009C; a following save_B computes with A=7.
REQ-034 rst_n pulsed low in MUL cycle 4 -> all outputs 0; after release a show_result is ignored.
REQ-035 CALC_ACCUMULATE_EN build: 12x13 published twice -> display 0x009C then 0x0138; 255x255 published twice -> 0xFC02 (wraps).
